// File: rtl/flash_stream_pkg.sv
// Shared types, defaults and helpers for the flash sample streamer.
package flash_stream_pkg;

    localparam int DEF_NUM_WORDS  = 524288;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int ADDR_W         = 23;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        FAST   = 2'd1,
        SLOW   = 2'd2
    } rate_mode_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_DATA = 3'd2,
        PUSH      = 3'd3,
        END       = 3'd4
    } stream_state_t;

    // Encoding 11 plays back at normal rate.
    function automatic rate_mode_t to_rate_mode(input logic [1:0] m);
        case (m)
            2'b01:   return FAST;
            2'b10:   return SLOW;
            default: return NORMAL;
        endcase
    endfunction

    function automatic logic [2:0] samples_per_word(input rate_mode_t m);
        case (m)
            FAST:    return 3'd1;
            SLOW:    return 3'd4;
            default: return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with free-slot count; simultaneous push/pop allowed at full or empty.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign free_count = CW'(DEPTH) - count;
    assign do_pop     = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign do_push    = push && (!full || do_pop);
    assign head_data  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/flash_sample_streamer.sv
// Streams 32-bit flash words as rate-adjusted 16-bit samples into a FIFO.
// Build option STREAM_LOOP_EN: wrap to address 0 after the last word instead of ending.
//   state     | meaning
//   IDLE      | latch mode, wait for enough free FIFO slots
//   REQ       | read request held until waitrequest drops
//   WAIT_DATA | wait for readdatavalid, capture word
//   PUSH      | one sample per cycle into the FIFO
//   END       | clip finished, no further reads
module flash_sample_streamer
    import flash_stream_pkg::*;
#(
    parameter int NUM_WORDS  = DEF_NUM_WORDS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [1:0]        mode,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    input  logic              flash_mem_waitrequest,
    input  logic [31:0]       flash_mem_readdata,
    input  logic              flash_mem_readdatavalid,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [15:0]       sample_data,
    output logic              done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    stream_state_t     state_q, state_d;
    rate_mode_t        mode_in, mode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       word_q;
    logic [1:0]        push_cnt_q;
    logic              fifo_push;
    logic [15:0]       push_sample;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_free;
    logic              last_word;
    logic              last_push;

    assign mode_in           = to_rate_mode(mode);
    assign last_word         = (addr_q == ADDR_W'(NUM_WORDS - 1));
    assign last_push         = (push_cnt_q == 2'd0);
    assign flash_mem_address = addr_q;
    assign sample_valid      = !fifo_empty;
    // Down-counter runs N-1..0; the upper half of its range selects the high half-word.
    assign push_sample = ({1'b0, push_cnt_q} >= (samples_per_word(mode_q) >> 1))
                         ? word_q[31:16] : word_q[15:0];

    always_ff @(posedge CLOCK_50) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        flash_mem_read = 1'b0;
        fifo_push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_full && fifo_free >= CW'(samples_per_word(mode_in)))
                    state_d = REQ;
            end
            REQ: begin
                flash_mem_read = 1'b1;
                if (!flash_mem_waitrequest) state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (flash_mem_readdatavalid) state_d = PUSH;
            end
            PUSH: begin
                fifo_push = 1'b1;
                if (last_push) begin
`ifdef STREAM_LOOP_EN
                    state_d = IDLE;
`else
                    state_d = last_word ? END : IDLE;
`endif
                end
            end
            END:     state_d = END;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            mode_q     <= NORMAL;
            push_cnt_q <= '0;
            addr_q     <= '0;
            word_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    mode_q     <= mode_in;
                    push_cnt_q <= 2'(samples_per_word(mode_in) - 3'd1);
                end
                WAIT_DATA: begin
                    if (flash_mem_readdatavalid) word_q <= flash_mem_readdata;
                end
                PUSH: begin
                    if (last_push) addr_q <= last_word ? '0 : addr_q + ADDR_W'(1);
                    else           push_cnt_q <= push_cnt_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef STREAM_LOOP_EN
    assign done = 1'b0;
`else
    logic done_q;
    always_ff @(posedge CLOCK_50) begin
        if (reset)                             done_q <= 1'b0;
        else if (state_q == END && fifo_empty) done_q <= 1'b1;
    end
    assign done = done_q;
`endif

    sample_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .push       (fifo_push),
        .push_data  (push_sample),
        .pop        (sample_ready),
        .head_data  (sample_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .free_count (fifo_free)
    );

endmodule
